// File: rtl/estado_mascota_pkg.sv
// Shared encodings and thresholds for the pet mood pipeline.
// Pure definitions; no latency or flow control.
package estado_mascota_pkg;

   typedef enum logic [2:0] {
      FELIZ      = 3'd0,
      NEUTRAL    = 3'd1,
      HAMBRIENTO = 3'd2,
      ABURRIDO   = 3'd3,
      CRITICO    = 3'd4,
      MUERTO     = 3'd5
   } estado_t;

   localparam logic [2:0] NIVEL_MIN = 3'd1;
   localparam logic [2:0] NIVEL_MAX = 3'd5;

   localparam logic [2:0] UMBRAL_HAMBRE    = 3'd4;
   localparam logic [2:0] UMBRAL_ABURRIDO  = 3'd2;
   localparam logic [2:0] UMBRAL_DIVERTIDO = 3'd4;
   localparam logic [2:0] UMBRAL_SACIADO   = 3'd2;

   // Out-of-range levels from upstream are pinned to the nearest legal level.
   function automatic logic [2:0] sujetar_nivel(input logic [2:0] nivel);
      if (nivel < NIVEL_MIN)
         return NIVEL_MIN;
      else if (nivel > NIVEL_MAX)
         return NIVEL_MAX;
      return nivel;
   endfunction

endpackage

// File: rtl/estado_mascota_clasificador.sv
// Clamp + priority classification of (hambre, diversion) into a mood state.
// Latency: combinational; no backpressure.
module clasificador_estado
   import estado_mascota_pkg::*;
(
   input  logic [2:0] nivel_hambre,
   input  logic [2:0] nivel_diversion,
   output estado_t    clase
);

   logic [2:0] hambre;
   logic [2:0] diversion;

   assign hambre    = sujetar_nivel(nivel_hambre);
   assign diversion = sujetar_nivel(nivel_diversion);

   always_comb begin
      clase = NEUTRAL;
      if (hambre == NIVEL_MAX || diversion == NIVEL_MIN)
         clase = CRITICO;
      else if (hambre >= UMBRAL_HAMBRE)
         clase = HAMBRIENTO;
      else if (diversion <= UMBRAL_ABURRIDO)
         clase = ABURRIDO;
      else if (hambre <= UMBRAL_SACIADO && diversion >= UMBRAL_DIVERTIDO)
         clase = FELIZ;
   end

endmodule

// File: rtl/estado_mascota.sv
// Filtered pet mood state with death timer and display test cycling.
// Latency: steady level shows after CLK_FREQ*SEG_ESTABLE+1 edges; no backpressure.
module estado_mascota
   import estado_mascota_pkg::*;
#(
   parameter int unsigned CLK_FREQ    = 50000000,
   parameter int unsigned SEG_ESTABLE = 1,
   parameter int unsigned SEG_MUERTE  = 30,
   parameter int unsigned SEG_TEST    = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] nivel_hambre,
   input  logic [2:0] nivel_diversion,
   input  logic       test,
   output logic [2:0] estado,
   output logic       cambio,
   output logic       alerta,
   output logic       muerto,
   output logic       modo_test
);

   localparam logic [31:0] CICLOS_ESTABLE = CLK_FREQ * SEG_ESTABLE;
   localparam logic [31:0] CICLOS_MUERTE  = CLK_FREQ * SEG_MUERTE;
   localparam logic [31:0] CICLOS_TEST    = CLK_FREQ * SEG_TEST;

   estado_t     clase;
   estado_t     candidato;
   estado_t     estado_real;
   estado_t     real_nxt;
   logic [31:0] cnt_estable;
   logic [31:0] cnt_muerte;
   logic [31:0] cnt_test;

   clasificador_estado u_clasificador (
      .nivel_hambre    (nivel_hambre),
      .nivel_diversion (nivel_diversion),
      .clase           (clase)
   );

   // Death takes precedence over a commit landing on the same edge.
   always_comb begin
      real_nxt = estado_real;
      if (estado_real == CRITICO && cnt_muerte == CICLOS_MUERTE - 32'd1)
         real_nxt = MUERTO;
      else if (estado_real != MUERTO && candidato != estado_real &&
               cnt_estable == CICLOS_ESTABLE - 32'd1)
         real_nxt = candidato;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         candidato   <= FELIZ;
         estado_real <= FELIZ;
         cnt_estable <= '0;
         cnt_muerte  <= '0;
         cnt_test    <= '0;
         estado      <= FELIZ;
         cambio      <= 1'b0;
         alerta      <= 1'b0;
         muerto      <= 1'b0;
         modo_test   <= 1'b0;
      end else begin
         candidato <= clase;
         if (clase != candidato)
            cnt_estable <= '0;
         else if (cnt_estable != '1)
            cnt_estable <= cnt_estable + 32'd1;

         estado_real <= real_nxt;
         cambio      <= (real_nxt != estado_real);
         alerta      <= (real_nxt == CRITICO);
         muerto      <= (real_nxt == MUERTO);
         cnt_muerte  <= (estado_real == CRITICO) ? cnt_muerte + 32'd1 : '0;

         // Display override; the real-state path above runs regardless.
         if (!test) begin
            if (!modo_test) begin
               modo_test <= 1'b1;
               estado    <= FELIZ;
               cnt_test  <= '0;
            end else if (cnt_test == CICLOS_TEST - 32'd1) begin
               cnt_test <= '0;
               estado   <= (estado == MUERTO) ? FELIZ : 3'(estado + 3'd1);
            end else begin
               cnt_test <= cnt_test + 32'd1;
            end
         end else begin
            modo_test <= 1'b0;
            cnt_test  <= '0;
            estado    <= real_nxt;
         end
      end
   end

endmodule

// File: tb/tb_estado_mascota.sv
// Directed bench for estado_mascota with short timers (10 cycles per second).
module tb_estado_mascota;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] nivel_hambre;
   logic [2:0] nivel_diversion;
   logic       test;
   logic [2:0] estado;
   logic       cambio;
   logic       alerta;
   logic       muerto;
   logic       modo_test;

   int n_chk = 0;
   int n_err = 0;
   int n_cambio = 0;
   int base;

   estado_mascota #(
      .CLK_FREQ    (10),
      .SEG_ESTABLE (1),
      .SEG_MUERTE  (3),
      .SEG_TEST    (1)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .nivel_hambre    (nivel_hambre),
      .nivel_diversion (nivel_diversion),
      .test            (test),
      .estado          (estado),
      .cambio          (cambio),
      .alerta          (alerta),
      .muerto          (muerto),
      .modo_test       (modo_test)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (reset === 1'b1 && cambio === 1'b1)
         n_cambio++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic niveles(input logic [2:0] h, input logic [2:0] d);
      nivel_hambre    = h;
      nivel_diversion = d;
   endtask

   task automatic reiniciar();
      reset = 1'b0;
      tick(1);
      reset = 1'b1;
      tick(2);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      test  = 1'b1;
      niveles(3'd1, 3'd5);
      tick(2);
      chk("rst_estado", 32'(estado), 0);
      chk("rst_cambio", 32'(cambio), 0);
      chk("rst_alerta", 32'(alerta), 0);
      chk("rst_muerto", 32'(muerto), 0);
      chk("rst_modo",   32'(modo_test), 0);
      reset = 1'b1;
      tick(12);
      chk("idle_estado", 32'(estado), 0);

      // Commit latency and single pulse
      base = n_cambio;
      niveles(3'd4, 3'd3);
      tick(10);
      chk("commit_early", 32'(estado), 0);
      tick(1);
      chk("commit_estado", 32'(estado), 2);
      chk("commit_cambio", 32'(cambio), 1);
      tick(1);
      chk("commit_cambio_off", 32'(cambio), 0);
      tick(20);
      chk("commit_pulsos", 32'(n_cambio - base), 1);

      // Short glitch is rejected, then a held NEUTRAL commits
      reiniciar();
      base = n_cambio;
      niveles(3'd4, 3'd5);
      tick(5);
      niveles(3'd1, 3'd5);
      tick(20);
      chk("glitch_estado", 32'(estado), 0);
      chk("glitch_pulsos", 32'(n_cambio - base), 0);
      niveles(3'd2, 3'd3);
      tick(10);
      chk("neutral_early", 32'(estado), 0);
      tick(1);
      chk("neutral_estado", 32'(estado), 1);

      // Clamp: 0 -> 1 and 7 -> 5 gives FELIZ
      niveles(3'd0, 3'd7);
      tick(11);
      chk("clamp_feliz", 32'(estado), 0);
      tick(2);

      // Death path, clamped hambre 7 counts as starving
      base = n_cambio;
      niveles(3'd7, 3'd4);
      tick(11);
      chk("crit_estado", 32'(estado), 4);
      chk("crit_alerta", 32'(alerta), 1);
      tick(29);
      chk("crit_vivo", 32'(estado), 4);
      chk("crit_muerto0", 32'(muerto), 0);
      tick(1);
      chk("muerte_estado", 32'(estado), 5);
      chk("muerte_muerto", 32'(muerto), 1);
      chk("muerte_alerta", 32'(alerta), 0);
      chk("muerte_cambio", 32'(cambio), 1);
      niveles(3'd1, 3'd5);
      tick(30);
      chk("muerte_sticky", 32'(estado), 5);
      chk("muerte_pulsos", 32'(n_cambio - base), 2);
      reiniciar();
      chk("revive_estado", 32'(estado), 0);
      chk("revive_muerto", 32'(muerto), 0);

      // Recovery clears the death timer
      niveles(3'd5, 3'd3);
      tick(11);
      chk("rec_crit", 32'(estado), 4);
      tick(9);
      niveles(3'd1, 3'd5);
      tick(10);
      chk("rec_aun_crit", 32'(estado), 4);
      tick(1);
      chk("rec_feliz", 32'(estado), 0);
      chk("rec_alerta", 32'(alerta), 0);
      niveles(3'd3, 3'd1);
      tick(11);
      chk("rec2_crit", 32'(estado), 4);
      tick(29);
      chk("rec2_vivo", 32'(estado), 4);
      tick(1);
      chk("rec2_muerto", 32'(estado), 5);

      // Test mode cycles the display while the real state keeps running
      reiniciar();
      test = 1'b0;
      niveles(3'd4, 3'd3);
      tick(1);
      chk("tm_modo", 32'(modo_test), 1);
      chk("tm_e0", 32'(estado), 0);
      tick(9);
      chk("tm_e0_hold", 32'(estado), 0);
      tick(1);
      chk("tm_e1", 32'(estado), 1);
      chk("tm_cambio", 32'(cambio), 1);
      for (int k = 2; k <= 6; k++) begin
         tick(10);
         chk("tm_seq", 32'(estado), 32'(k % 6));
      end
      chk("tm_alerta", 32'(alerta), 0);
      test = 1'b1;
      tick(1);
      chk("tm_sale_estado", 32'(estado), 2);
      chk("tm_sale_modo", 32'(modo_test), 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/estado_mascota.md
Name: estado_mascota

Overview:
- Downstream consumer of the hunger/fun level block. Converts nivel_hambre and nivel_diversion (1..5) into a committed pet mood state for the display/animation stage.
- Applies a stability filter so that level glitches are not shown, and runs a death timer while the pet is critical.
- Provides a test mode that cycles through every state for display checking.

Parameters:
- CLK_FREQ, 50000000, clock frequency in Hz; timers are cycle-exact multiples of it.
- SEG_ESTABLE, 1, seconds a new classification must persist before it is committed.
- SEG_MUERTE, 30, seconds of continuous committed CRITICO before MUERTO.
- SEG_TEST, 2, seconds per state in test mode.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- nivel_hambre  input  3  hunger level, 1=full, 5=starving.
- nivel_diversion  input  3  fun level, 1=bored, 5=max.
- test  input  1  active-low, already-debounced test level.
- estado  output  3  displayed state: FELIZ=0, NEUTRAL=1, HAMBRIENTO=2, ABURRIDO=3, CRITICO=4, MUERTO=5.
- cambio  output  1  one-cycle pulse when the real state commits a new value.
- alerta  output  1  1 while the real state is CRITICO.
- muerto  output  1  1 while the real state is MUERTO.
- modo_test  output  1  1 while test mode is active.

Behaviour:
- Reset: clk and reset are one clock; reset is synchronous and active-low. Reset wins over all other events.
  - On reset: real state = FELIZ, candidato = FELIZ, all counters = 0, estado=0, cambio=0, alerta=0, muerto=0, modo_test=0.
- Input clamp: level 0 is treated as 1; levels 6 and 7 are treated as 5.
- Classification (combinational, first match wins):
  - CRITICO if hambre==5 or diversion==1.
  - HAMBRIENTO if hambre>=4.
  - ABURRIDO if diversion<=2.
  - FELIZ if hambre<=2 and diversion>=4.
  - Otherwise NEUTRAL.
- candidato register:
  - Loads the classification every edge.
  - When the classification differs from candidato, cnt_estable is reset to 0; otherwise cnt_estable increments and saturates.
- Commit:
  - Occurs on the edge where cnt_estable == CLK_FREQ*SEG_ESTABLE-1, candidato != real state, and the real state != MUERTO.
  - On commit: real state <= candidato and cambio=1 for exactly that cycle.
  - Latency: a level change held steady at edge N appears at edge N+CLK_FREQ*SEG_ESTABLE+1.
  - A classification lasting fewer cycles than that produces no commit and no pulse.
- Death timer:
  - cnt_muerte increments each cycle the real state is CRITICO.
  - It clears on any cycle the real state is not CRITICO.
  - At cnt_muerte == CLK_FREQ*SEG_MUERTE-1 the next edge sets real state to MUERTO and pulses cambio.
- MUERTO is sticky: levels are ignored and only reset exits it.
- alerta and muerto are registered decodes of the real state.
- Test mode:
  - The edge seeing test==0 sets modo_test=1, sets estado=FELIZ, and clears cnt_test.
  - Each CLK_FREQ*SEG_TEST cycles estado advances 0..5, then wraps to 0.
  - The edge seeing test==1 clears modo_test and sets estado to the real state.
  - While in test mode, the real-state logic, timers, cambio, alerta and muerto keep running unaffected.
- Outside test mode, estado == real state.
- Counters are 32-bit; parameter products must fit in 32 bits.

Decomposition:
- Shared package contents:
  - 3-bit state encodings FELIZ..MUERTO.
  - Level limits NIVEL_MIN=1, NIVEL_MAX=5.
  - Classification thresholds (4, 2, 4).
- Natural sub-module: clasificador_estado, combinational. It performs clamp + priority classification: (hambre, diversion) -> 3-bit state.
- Remaining logic (timers, commit, test mode) stays in estado_mascota.

Test Plan (CLK_FREQ=10, SEG_ESTABLE=1, SEG_MUERTE=3, SEG_TEST=1):
- Reset: reset=0 for 2 cycles with h=1, d=5 -> estado=0, cambio=0, alerta=0, muerto=0, modo_test=0.
- Commit: h=4, d=3 steady from edge N -> estado=2 at edge N+11; cambio high exactly one cycle; no further pulses.
- Glitch rejection: h=4 for 5 cycles, then back to 1 -> estado stays 0, no cambio. With h=2, d=3 held 11 cycles -> estado=1.
- Death: h=5 -> estado=4, alerta=1 after 11 edges. 30 further cycles -> estado=5, muerto=1, alerta=0, one cambio pulse. Then h=1, d=5 -> stays 5. reset=0 -> estado=0.
- Recovery: enter CRITICO, hold 20 cycles, then h=1, d=5 -> FELIZ commits. Re-enter CRITICO -> MUERTO only after a full 30 committed-critical cycles.
- Test mode: test=0 -> modo_test=1, estado sequence 0,1,2,3,4,5,0 changing every 10 cycles. Meanwhile an h=4 change still pulses cambio. test=1 -> next edge estado=real state (2), modo_test=0.
